ps2_key_event_queue: RTL and testbench



---
 rtl/ps2_queue_pkg.sv | 13 +
 rtl/ps2_queue_mem.sv | 40 ++++
 rtl/ps2_key_event_queue.sv | 103 ++++++++++
 tb/tb_ps2_key_event_queue.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_queue_pkg.sv
// Shared constants for the PS/2 key event queue: default geometry,
// interrupt mode selectors and the code value treated as "no key".
package ps2_queue_pkg;

    localparam int DEF_CODE_W = 8;
    localparam int DEF_DEPTH  = 8;

    localparam int IRQ_LEVEL  = 0;
    localparam int IRQ_PULSE  = 1;

    localparam int NULL_CODE  = 0;

endpackage

// File: rtl/ps2_queue_mem.sv
// DEPTH x CODE_W storage for the key queue with one write port and a
// registered head read that already reflects this cycle's push/pop.
module ps2_queue_mem
    import ps2_queue_pkg::*;
#(
    parameter int CODE_W = DEF_CODE_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              wr_en,
    input  logic [PW-1:0]     wr_addr,
    input  logic [CODE_W-1:0] wr_data,
    input  logic [PW-1:0]     rd_addr,
    input  logic              rd_valid,
    output logic [CODE_W-1:0] head
);

    logic [CODE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // A write landing on the next head slot (push into an empty queue, or
    // push+pop at count 1) must be forwarded, since the array is not yet updated.
    always_ff @(posedge clk) begin
        if (Reset)
            head <= '0;
        else if (!rd_valid)
            head <= '0;
        else if (wr_en && (wr_addr == rd_addr))
            head <= wr_data;
        else
            head <= mem[rd_addr];
    end

endmodule

// File: rtl/ps2_key_event_queue.sv
// Key code FIFO between the PS/2 keyboard unit and the processor: owns the
// pointers, occupancy counter, status flags, interrupt and keyboard release.
module ps2_key_event_queue
    import ps2_queue_pkg::*;
#(
    parameter int CODE_W    = DEF_CODE_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int IRQ_PULSE = IRQ_LEVEL,
    parameter int DROP_ZERO = 1,
    localparam int PW       = $clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              key_stb,
    input  logic [CODE_W-1:0] key_code,
    output logic              key_done,
    input  logic              rd_ack,
    input  logic              clr_ovf,
    output logic [CODE_W-1:0] head_code,
    output logic              irq,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] rd_ptr_next;
    logic [CW-1:0] count_next;
    logic          want_push;
    logic          do_push;
    logic          do_pop;
    logic          ovf_set;
    logic          irq_next;

    always_comb begin
        want_push   = 1'b0;
        do_pop      = 1'b0;
        do_push     = 1'b0;
        ovf_set     = 1'b0;
        rd_ptr_next = rd_ptr;
        count_next  = count;
        irq_next    = 1'b0;

        want_push = key_stb && !((DROP_ZERO != 0) && (key_code == CODE_W'(NULL_CODE)));
        do_pop    = rd_ack && (count != '0);
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        do_push   = want_push && ((count != CW'(DEPTH)) || do_pop);
        ovf_set   = want_push && !do_push;

        if (do_pop)
            rd_ptr_next = rd_ptr + PW'(1);
        count_next = count + CW'(do_push) - CW'(do_pop);

        if (IRQ_PULSE == ps2_queue_pkg::IRQ_PULSE)
            irq_next = (do_push && (count == '0)) || (do_pop && (count_next != '0));
        else
            irq_next = (count_next != '0);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            irq      <= 1'b0;
            key_done <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr   <= rd_ptr_next;
            count    <= count_next;
            empty    <= (count_next == '0);
            full     <= (count_next == CW'(DEPTH));
            irq      <= irq_next;
            key_done <= key_stb;
            if (ovf_set)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    ps2_queue_mem #(
        .CODE_W (CODE_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk      (clk),
        .Reset    (Reset),
        .wr_en    (do_push),
        .wr_addr  (wr_ptr),
        .wr_data  (key_code),
        .rd_addr  (rd_ptr_next),
        .rd_valid (count_next != '0),
        .head     (head_code)
    );

endmodule

// File: tb/tb_ps2_key_event_queue.sv
// Drives a level-irq and a pulse-irq instance with identical stimulus and
// compares both against a queue-based reference model every cycle.
module tb_ps2_key_event_queue;

    localparam int CODE_W = 8;
    localparam int DEPTH  = 8;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              key_stb;
    logic [CODE_W-1:0] key_code;
    logic              rd_ack;
    logic              clr_ovf;

    logic              done_l, irq_l, empty_l, full_l, ovf_l;
    logic [CODE_W-1:0] head_l;
    logic [CW-1:0]     count_l;
    logic              done_p, irq_p, empty_p, full_p, ovf_p;
    logic [CODE_W-1:0] head_p;
    logic [CW-1:0]     count_p;

    always #5 clk = ~clk;

    ps2_key_event_queue #(.CODE_W(CODE_W), .DEPTH(DEPTH), .IRQ_PULSE(0), .DROP_ZERO(1)) dut_lvl (
        .clk(clk), .Reset(rst), .key_stb(key_stb), .key_code(key_code), .key_done(done_l),
        .rd_ack(rd_ack), .clr_ovf(clr_ovf), .head_code(head_l), .irq(irq_l),
        .count(count_l), .empty(empty_l), .full(full_l), .overflow(ovf_l)
    );

    ps2_key_event_queue #(.CODE_W(CODE_W), .DEPTH(DEPTH), .IRQ_PULSE(1), .DROP_ZERO(1)) dut_pls (
        .clk(clk), .Reset(rst), .key_stb(key_stb), .key_code(key_code), .key_done(done_p),
        .rd_ack(rd_ack), .clr_ovf(clr_ovf), .head_code(head_p), .irq(irq_p),
        .count(count_p), .empty(empty_p), .full(full_p), .overflow(ovf_p)
    );

    int q_code[$];
    int q_id[$];
    int next_id;
    int exp_ovf, exp_done, exp_irq_lvl, exp_irq_pls;
    int tests_run, tests_failed;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock, update the model with the inputs seen at the edge,
    // then compare every output of both instances.
    task automatic step();
        int old_size, old_head_id, new_head_id, exp_head;
        bit accept, popping;
        @(posedge clk);
        if (rst) begin
            q_code.delete();
            q_id.delete();
            exp_ovf = 0; exp_done = 0; exp_irq_lvl = 0; exp_irq_pls = 0;
        end else begin
            old_size    = q_code.size();
            old_head_id = (old_size > 0) ? q_id[0] : -1;
            exp_done    = key_stb;
            accept      = key_stb && (key_code != 0);
            popping     = rd_ack && (old_size > 0);
            if (popping) begin
                void'(q_code.pop_front());
                void'(q_id.pop_front());
            end
            if (accept && old_size == DEPTH && !popping)
                exp_ovf = 1;
            else begin
                if (accept) begin
                    q_code.push_back(key_code);
                    q_id.push_back(next_id);
                    next_id++;
                end
                if (clr_ovf) exp_ovf = 0;
            end
            new_head_id = (q_code.size() > 0) ? q_id[0] : -1;
            exp_irq_lvl = (q_code.size() > 0);
            exp_irq_pls = (q_code.size() > 0) && (new_head_id != old_head_id);
        end
        #1;
        exp_head = (q_code.size() > 0) ? q_code[0] : 0;
        check("lvl.head",  32'(head_l),  32'(exp_head));
        check("lvl.count", 32'(count_l), 32'(q_code.size()));
        check("lvl.empty", 32'(empty_l), 32'(q_code.size() == 0));
        check("lvl.full",  32'(full_l),  32'(q_code.size() == DEPTH));
        check("lvl.ovf",   32'(ovf_l),   32'(exp_ovf));
        check("lvl.done",  32'(done_l),  32'(exp_done));
        check("lvl.irq",   32'(irq_l),   32'(exp_irq_lvl));
        check("pls.head",  32'(head_p),  32'(exp_head));
        check("pls.count", 32'(count_p), 32'(q_code.size()));
        check("pls.ovf",   32'(ovf_p),   32'(exp_ovf));
        check("pls.done",  32'(done_p),  32'(exp_done));
        check("pls.irq",   32'(irq_p),   32'(exp_irq_pls));
    endtask

    task automatic push(input logic [7:0] code);
        key_stb = 1'b1; key_code = code;
        step();
        key_stb = 1'b0; key_code = '0;
    endtask

    task automatic pop();
        rd_ack = 1'b1;
        step();
        rd_ack = 1'b0;
    endtask

    initial begin
        tests_run = 0; tests_failed = 0; next_id = 0;
        exp_ovf = 0; exp_done = 0; exp_irq_lvl = 0; exp_irq_pls = 0;
        rst = 1'b1; key_stb = 1'b0; key_code = '0; rd_ack = 1'b0; clr_ovf = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        push(8'h41); push(8'h42); push(8'h43);
        step();
        check("plan.head41", 32'(head_l), 32'h41);
        check("plan.count3", 32'(count_l), 32'd3);
        check("plan.irq1",   32'(irq_l), 32'd1);
        pop(); check("plan.head42", 32'(head_l), 32'h42);
        pop(); check("plan.head43", 32'(head_l), 32'h43);
        pop(); check("plan.head00", 32'(head_l), 32'h00);
        pop(); check("plan.empty_pop", 32'(count_l), 32'd0);

        for (int i = 0; i < DEPTH; i++) push(8'h10 + 8'(i));
        push(8'h5A);
        check("plan.ovf", 32'(ovf_l), 32'd1);
        check("plan.full", 32'(full_l), 32'd1);
        clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
        check("plan.ovf_clr", 32'(ovf_l), 32'd0);

        key_stb = 1'b1; key_code = 8'h31; rd_ack = 1'b1;
        step();
        key_stb = 1'b0; key_code = '0; rd_ack = 1'b0;
        check("plan.full_pushpop", 32'(count_l), 32'd8);
        for (int i = 0; i < DEPTH - 1; i++) pop();
        check("plan.last31", 32'(head_l), 32'h31);
        pop();

        push(8'h00);
        check("plan.zero_drop", 32'(count_l), 32'd0);
        push(8'h61); push(8'h62); pop(); pop(); step();

        // Overflow set and clear in the same cycle: set must win.
        for (int i = 0; i < DEPTH; i++) push(8'h70 + 8'(i));
        key_stb = 1'b1; key_code = 8'h7F; clr_ovf = 1'b1;
        step();
        key_stb = 1'b0; clr_ovf = 1'b0;
        check("plan.set_wins", 32'(ovf_l), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;

        for (int i = 0; i < 5; i++) push(8'h20 + 8'(i));
        rst = 1'b1; key_stb = 1'b1; key_code = 8'h55;
        step();
        rst = 1'b0; key_stb = 1'b0;
        check("plan.rst_count", 32'(count_l), 32'd0);
        check("plan.rst_done",  32'(done_l), 32'd0);
        step();

        for (int n = 0; n < 3000; n++) begin
            key_stb  = ($urandom_range(0, 99) < 45);
            key_code = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            rd_ack   = ($urandom_range(0, 99) < 40);
            clr_ovf  = ($urandom_range(0, 99) < 5);
            rst      = ($urandom_range(0, 999) < 4);
            step();
        end
        key_stb = 1'b0; rd_ack = 1'b0; clr_ovf = 1'b0; rst = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
